// File: rtl/axis_result_packetizer.sv
// Result-word FIFO that emits AXI4-Stream packets, closing each packet after PKT_LEN beats or on flush.
// The newest unterminated word is held back so that a later flush can still mark it as the last beat.
module axis_result_packetizer #(
   parameter int C_AXIS_TDATA_WIDTH = 8,
   parameter int DEPTH              = 16,
   parameter int PKT_LEN            = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          flush,
   output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
   output logic                          m00_axis_tvalid,
   input  logic                          m00_axis_tready,
   output logic                          m00_axis_tlast,
   output logic [15:0]                   pkt_count,
   output logic                          overflow
);

   localparam int              AW        = $clog2(DEPTH);
   localparam int              CW        = AW + 1;
   localparam logic [15:0]     LAST_BEAT = 16'(PKT_LEN - 1);
   localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);

   logic [C_AXIS_TDATA_WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]              flag_q;
   logic [AW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, newest_s;
   logic [CW-1:0]                 count_q, count_d;
   logic [15:0]                   beat_q, beat_d, pkt_q, pkt_d;
   logic                          ovf_q, ovf_d;
   logic                          full_s, empty_s, head_flag_s, valid_s;
   logic                          push_s, pop_s, push_last_s, mark_s;

   // Occupancy, presentability and the push/pop/flush decisions for this cycle.
   always_comb begin
      full_s      = (count_q == DEPTH_C);
      empty_s     = (count_q == {CW{1'b0}});
      head_flag_s = flag_q[rd_ptr_q];
      valid_s     = (count_q >= CW'(2)) | (~empty_s & head_flag_s);
      push_s      = in_valid & ~full_s;
      pop_s       = valid_s & m00_axis_tready;
      push_last_s = (beat_q == LAST_BEAT) | flush;
      // A flush without an accepted write terminates the newest buffered word.
      mark_s      = flush & ~push_s & (beat_q != 16'd0);
      newest_s    = wr_ptr_q - AW'(1);
   end

   // Next-state values for pointers, counters and the sticky overflow flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      beat_d   = beat_q;
      count_d  = count_q;
      pkt_d    = pkt_q;
      ovf_d    = ovf_q | (in_valid & full_s);
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (push_last_s) begin
            beat_d = 16'd0;
         end else begin
            beat_d = beat_q + 16'd1;
         end
      end else if (mark_s) begin
         beat_d = 16'd0;
      end else begin
         beat_d = beat_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         pkt_d    = pkt_q + {15'd0, head_flag_s};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers plus the data and last-flag arrays.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
         beat_q   <= 16'd0;
         pkt_q    <= 16'd0;
         ovf_q    <= 1'b0;
         flag_q   <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= {C_AXIS_TDATA_WIDTH{1'b0}};
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         beat_q   <= beat_d;
         pkt_q    <= pkt_d;
         ovf_q    <= ovf_d;
         if (pop_s) begin
            flag_q[rd_ptr_q] <= 1'b0;
         end
         if (push_s) begin
            data_q[wr_ptr_q] <= in_data;
            flag_q[wr_ptr_q] <= push_last_s;
         end
         if (mark_s) begin
            flag_q[newest_s] <= 1'b1;
         end
      end
   end

   assign in_ready        = ~full_s & ~rst;
   assign m00_axis_tvalid = valid_s;
   assign m00_axis_tdata  = empty_s ? {C_AXIS_TDATA_WIDTH{1'b0}} : data_q[rd_ptr_q];
   assign m00_axis_tlast  = ~empty_s & head_flag_s;
   assign pkt_count       = pkt_q;
   assign overflow        = ovf_q;

endmodule

// File: doc/axis_result_packetizer.md
# axis_result_packetizer

Transmit-side AXI4-Stream master for the PS-PL data path. It accepts result words from a PL processing core through a simple valid/ready push port and buffers them in a small FIFO. It emits them as AXI4-Stream packets toward the DMA S2MM channel, with tlast asserted correctly on the final beat of each packet. A packet closes either after PKT_LEN beats or on an explicit flush from the core.

## Interface
- C_AXIS_TDATA_WIDTH, 8: width of in_data and m00_axis_tdata.
- DEPTH, 16: FIFO entries; power of two, minimum 4.
- PKT_LEN, 16: beats per full packet; range 1..65535.

- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- in_data  in  C_AXIS_TDATA_WIDTH  result word from the core.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  space available; equals ~full. Held 0 while rst is high.
- flush  in  1  one-cycle pulse that closes the current packet.
- m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  stream data.
- m00_axis_tvalid  out  1  stream beat valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tlast  out  1  final beat of a packet.
- pkt_count  out  16  packets fully transmitted; wraps at 2^16.
- overflow  out  1  sticky; set when in_valid arrives while full. Cleared only by rst.

## Operation
- Storage:
  - DEPTH x C_AXIS_TDATA_WIDTH data array plus a separate DEPTH x 1 last-flag array.
  - Write pointer, read pointer, and a count of 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Write:
  - Accepted when in_valid & ~full. The word is stored at wr_ptr and wr_ptr advances modulo DEPTH.
  - beat_cnt (16 bit) advances on each accepted write.
  - The entry's flag is set if beat_cnt == PKT_LEN-1 or flush is high in the same cycle. beat_cnt then returns to 0.
- Write while full:
  - The word is dropped and overflow is set.
  - beat_cnt is unchanged; a simultaneous read does not rescue it.
- Flush with no accepted write:
  - If beat_cnt > 0, set the flag of entry wr_ptr-1 (newest) and clear beat_cnt.
  - If beat_cnt == 0, no effect; empty packets are never generated.
- Hold-back rule:
  - The head entry is presentable only if count >= 2 or its flag is set.
  - Consequence: the newest unterminated word is always still in the FIFO, so a flush can mark it.
- Output:
  - m00_axis_tvalid = presentable.
  - tdata and tlast are read combinationally from the entry at rd_ptr.
  - A pop occurs on tvalid & tready; rd_ptr advances modulo DEPTH and that entry's flag is cleared.
- pkt_count increments on each pop with tlast = 1.
- Simultaneous push and pop: count is unchanged and both pointers advance.

## Timing
- Reset values:
  - in_ready 0 during reset, 1 in the first cycle after reset.
  - m00_axis_tvalid 0, m00_axis_tlast 0, m00_axis_tdata 0 (array cleared or masked when empty), pkt_count 0, overflow 0.
  - All pointers, count, beat_cnt and flags cleared.
- Latency: a word written in cycle N is visible on m00 in cycle N+1, provided that after the write count >= 2 or the word's flag is set.
- Throughput: 1 beat/cycle sustained once at least 2 entries are buffered.
- AXIS compliance:
  - Once tvalid rises it stays high, with tdata and tlast stable, until accepted.
  - count never decreases without a pop, and flags are only ever set on unpopped entries.
- tvalid never depends combinationally on tready.
- Flush takes effect on the flag in the same clock edge, so tvalid/tlast can rise in cycle N+1.
- Reset mid-packet: all buffered data is discarded and the next accepted word starts a new packet.

## Test plan
- PKT_LEN=4, push 8 words 0x01..0x08 back-to-back with tready=1 -> 8 beats in order, tlast on 0x04 and 0x08, pkt_count=2.
- PKT_LEN=16, push 0xA0,0xA1,0xA2, then flush alone 3 cycles later -> 0xA0,0xA1 stream out, 0xA2 held until the flush, then emitted with tlast=1 one cycle after the flush; pkt_count=1.
- DEPTH=16, tready=0, push 17 words -> in_ready falls after the 16th, the 17th is dropped, overflow=1. Release tready -> exactly 16 beats emitted, data intact.
- Randomized tready with PKT_LEN=5, 40 words -> tdata/tlast stable while tvalid & ~tready, tlast on every 5th beat, pkt_count=8.
- Flush with beat_cnt=0 -> no beat and no tlast. Flush coincident with a push of 0x55 -> 0x55 carries tlast.
- Assert rst with 3 words buffered -> tvalid=0 next cycle, pkt_count=0. A subsequent push of 0x11 with flush emits 0x11 with tlast as a fresh packet.
